// File: rtl/ctrl_pkg.sv
// Shared encodings for the control pipeline: opcodes, ALU/immediate/writeback
// selects, forwarding selects and the decoded control bundle.
package ctrl_pkg;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  localparam logic [6:0] Funct7MulDiv = 7'b0000001;
  localparam logic [2:0] Funct3Mul    = 3'b000;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluSll   = 4'd2,
    AluSlt   = 4'd3,
    AluSltu  = 4'd4,
    AluXor   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluOr    = 4'd8,
    AluAnd   = 4'd9,
    AluPassB = 4'd10,
    AluMul   = 4'd11
  } alu_sel_e;

  typedef enum logic [2:0] {
    ImmI = 3'b000,
    ImmS = 3'b001,
    ImmU = 3'b010,
    ImmB = 3'b011,
    ImmJ = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    DdMem = 2'b00,
    DdAlu = 2'b01,
    DdPc4 = 2'b10
  } ddata_sel_e;

  localparam logic [1:0] FwdRf  = 2'b00;
  localparam logic [1:0] FwdMem = 2'b10;
  localparam logic [1:0] FwdWb  = 2'b01;

  // asrc=1 selects PC as operand A; bsrc=1 selects the immediate as operand B.
  typedef struct packed {
    logic       regwen;
    logic       memwen;
    logic       memrd;
    logic       asrc;
    logic       bsrc;
    logic       branch;
    logic       jump;
    alu_sel_e   alusel;
    ddata_sel_e ddatasel;
  } ctrl_t;

  // SUB exists only in R-type; SRA/SRAI are both selected by bit 30.
  function automatic alu_sel_e alu_decode(logic [2:0] funct3, logic bit30, logic is_rtype);
    case (funct3)
      3'b000:  return (is_rtype && bit30) ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return bit30 ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder for the ID stage.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned RA_W      = 5,
  parameter bit          MULDIV_EN = 1'b0
) (
  input  logic [31:0]     instr_i,
  output ctrl_t           ctrl_o,
  output logic            legal_o,
  output logic [2:0]      immsrc_o,
  output logic            use_rs1_o,
  output logic            use_rs2_o,
  output logic [RA_W-1:0] rd_o,
  output logic [RA_W-1:0] rs1_o,
  output logic [RA_W-1:0] rs2_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       use_rs1, use_rs2;
  imm_src_e   immsrc;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // Opcode decode into the control bundle and register-usage flags.
  always_comb begin
    ctrl_o  = '0;
    legal_o = 1'b1;
    immsrc  = ImmI;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OpcLoad: begin
        ctrl_o.regwen   = 1'b1;
        ctrl_o.memrd    = 1'b1;
        ctrl_o.bsrc     = 1'b1;
        ctrl_o.ddatasel = DdMem;
        use_rs1         = 1'b1;
      end
      OpcStore: begin
        ctrl_o.memwen = 1'b1;
        ctrl_o.bsrc   = 1'b1;
        immsrc        = ImmS;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OpcOp: begin
        ctrl_o.regwen   = 1'b1;
        ctrl_o.ddatasel = DdAlu;
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
        if (funct7 == Funct7MulDiv) begin
          // Only MUL of the M extension is implemented, and only when enabled.
          if (MULDIV_EN && funct3 == Funct3Mul) ctrl_o.alusel = AluMul;
          else                                  legal_o       = 1'b0;
        end else begin
          ctrl_o.alusel = alu_decode(funct3, instr_i[30], 1'b1);
        end
      end
      OpcOpImm: begin
        ctrl_o.regwen   = 1'b1;
        ctrl_o.bsrc     = 1'b1;
        ctrl_o.ddatasel = DdAlu;
        ctrl_o.alusel   = alu_decode(funct3, instr_i[30], 1'b0);
        use_rs1         = 1'b1;
      end
      OpcLui: begin
        ctrl_o.regwen   = 1'b1;
        ctrl_o.bsrc     = 1'b1;
        ctrl_o.alusel   = AluPassB;
        ctrl_o.ddatasel = DdAlu;
        immsrc          = ImmU;
      end
      OpcAuipc: begin
        ctrl_o.regwen   = 1'b1;
        ctrl_o.asrc     = 1'b1;
        ctrl_o.bsrc     = 1'b1;
        ctrl_o.ddatasel = DdAlu;
        immsrc          = ImmU;
      end
      OpcBranch: begin
        // ALU forms the target PC+imm; the comparison result arrives from EX.
        ctrl_o.branch = 1'b1;
        ctrl_o.asrc   = 1'b1;
        ctrl_o.bsrc   = 1'b1;
        immsrc        = ImmB;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OpcJal: begin
        ctrl_o.jump     = 1'b1;
        ctrl_o.regwen   = 1'b1;
        ctrl_o.asrc     = 1'b1;
        ctrl_o.bsrc     = 1'b1;
        ctrl_o.ddatasel = DdPc4;
        immsrc          = ImmJ;
      end
      OpcJalr: begin
        ctrl_o.jump     = 1'b1;
        ctrl_o.regwen   = 1'b1;
        ctrl_o.bsrc     = 1'b1;
        ctrl_o.ddatasel = DdPc4;
        use_rs1         = 1'b1;
      end
      default: legal_o = 1'b0;
    endcase
  end

  assign immsrc_o  = immsrc;
  // Illegal encodings must not create hazards.
  assign use_rs1_o = use_rs1 & legal_o;
  assign use_rs2_o = use_rs2 & legal_o;
  // Non-writing instructions report x0 so rd never aliases immediate bits.
  assign rd_o      = ctrl_o.regwen ? instr_i[7 +: RA_W] : '0;
  assign rs1_o     = instr_i[15 +: RA_W];
  assign rs2_o     = instr_i[20 +: RA_W];

endmodule

// File: rtl/ctrl_pipeline.sv
// Control path of a 5-stage pipeline: ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, branch/jump flush and operand forwarding selects.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int unsigned RA_W      = 5,
  parameter bit          MULDIV_EN = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic            ex_br_cond,
  output logic [2:0]      id_immsrc,
  output logic            ex_valid,
  output logic            ex_regwen,
  output logic            ex_memwen,
  output logic            ex_memrd,
  output logic            ex_asrc,
  output logic            ex_bsrc,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic [3:0]      ex_alusel,
  output logic [RA_W-1:0] ex_rd,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic            mem_valid,
  output logic            mem_regwen,
  output logic            mem_memwen,
  output logic [1:0]      mem_ddatasel,
  output logic [RA_W-1:0] mem_rd,
  output logic            wb_valid,
  output logic            wb_regwen,
  output logic [1:0]      wb_ddatasel,
  output logic [RA_W-1:0] wb_rd,
  output logic            pc_src,
  output logic            stall,
  output logic            flush_id,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            ex_illegal
);

  ctrl_t           dec_ctrl;
  logic            dec_legal, dec_use_rs1, dec_use_rs2;
  logic [RA_W-1:0] dec_rd, dec_rs1, dec_rs2;

  ctrl_decode #(
    .RA_W      (RA_W),
    .MULDIV_EN (MULDIV_EN)
  ) u_decode (
    .instr_i   (id_instr),
    .ctrl_o    (dec_ctrl),
    .legal_o   (dec_legal),
    .immsrc_o  (id_immsrc),
    .use_rs1_o (dec_use_rs1),
    .use_rs2_o (dec_use_rs2),
    .rd_o      (dec_rd),
    .rs1_o     (dec_rs1),
    .rs2_o     (dec_rs2)
  );

  logic            ex_valid_d, ex_valid_q, ex_illegal_d, ex_illegal_q;
  ctrl_t           ex_ctrl_d, ex_ctrl_q;
  logic [RA_W-1:0] ex_rd_d, ex_rd_q, ex_rs1_d, ex_rs1_q, ex_rs2_d, ex_rs2_q;
  logic            mem_valid_q, mem_regwen_q, mem_memwen_q;
  logic [1:0]      mem_ddatasel_q;
  logic [RA_W-1:0] mem_rd_q;
  logic            wb_valid_q, wb_regwen_q;
  logic [1:0]      wb_ddatasel_q;
  logic [RA_W-1:0] wb_rd_q;
  logic            load_use, mem_fwd_ok, wb_fwd_ok;

  // Redirect on a taken branch or any jump sitting in EX.
  assign pc_src = ex_valid_q & ((ex_ctrl_q.branch & ex_br_cond) | ex_ctrl_q.jump);

  // A load in EX whose result the ID instruction needs next cycle.
  assign load_use = ex_valid_q & ex_ctrl_q.memrd & (ex_rd_q != '0) & id_valid &
                    ((dec_use_rs1 & (dec_rs1 == ex_rd_q)) |
                     (dec_use_rs2 & (dec_rs2 == ex_rd_q)));

  // The flushed ID instruction is discarded anyway, so a flush cancels the stall.
  assign stall    = load_use & ~pc_src;
  assign flush_id = pc_src;

  // ID/EX next state: bubble on flush/stall, flagged bubble on illegal.
  always_comb begin
    ex_valid_d   = 1'b0;
    ex_illegal_d = 1'b0;
    ex_ctrl_d    = '0;
    ex_rd_d      = '0;
    ex_rs1_d     = '0;
    ex_rs2_d     = '0;
    if (pc_src || load_use) begin
      ex_valid_d = 1'b0;
    end else if (id_valid && !dec_legal) begin
      ex_illegal_d = 1'b1;
    end else if (id_valid) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = dec_ctrl;
      ex_rd_d    = dec_rd;
      ex_rs1_d   = dec_rs1;
      ex_rs2_d   = dec_rs2;
    end
  end

  // Pipeline registers; EX/MEM and MEM/WB advance unconditionally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_illegal_q   <= 1'b0;
      ex_ctrl_q      <= '0;
      ex_rd_q        <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      mem_valid_q    <= 1'b0;
      mem_regwen_q   <= 1'b0;
      mem_memwen_q   <= 1'b0;
      mem_ddatasel_q <= '0;
      mem_rd_q       <= '0;
      wb_valid_q     <= 1'b0;
      wb_regwen_q    <= 1'b0;
      wb_ddatasel_q  <= '0;
      wb_rd_q        <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_illegal_q   <= ex_illegal_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_rd_q        <= ex_rd_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      mem_valid_q    <= ex_valid_q;
      mem_regwen_q   <= ex_ctrl_q.regwen;
      mem_memwen_q   <= ex_ctrl_q.memwen;
      mem_ddatasel_q <= ex_ctrl_q.ddatasel;
      mem_rd_q       <= ex_rd_q;
      wb_valid_q     <= mem_valid_q;
      wb_regwen_q    <= mem_regwen_q;
      wb_ddatasel_q  <= mem_ddatasel_q;
      wb_rd_q        <= mem_rd_q;
    end
  end

  assign mem_fwd_ok = mem_valid_q & mem_regwen_q & (mem_rd_q != '0);
  assign wb_fwd_ok  = wb_valid_q & wb_regwen_q & (wb_rd_q != '0);

  // Forwarding selects; the younger MEM result wins over WB.
  always_comb begin
    fwd_a = FwdRf;
    fwd_b = FwdRf;
    if (mem_fwd_ok && (mem_rd_q == ex_rs1_q))     fwd_a = FwdMem;
    else if (wb_fwd_ok && (wb_rd_q == ex_rs1_q))  fwd_a = FwdWb;
    if (mem_fwd_ok && (mem_rd_q == ex_rs2_q))     fwd_b = FwdMem;
    else if (wb_fwd_ok && (wb_rd_q == ex_rs2_q))  fwd_b = FwdWb;
  end

  assign ex_valid     = ex_valid_q;
  assign ex_illegal   = ex_illegal_q;
  assign ex_regwen    = ex_ctrl_q.regwen;
  assign ex_memwen    = ex_ctrl_q.memwen;
  assign ex_memrd     = ex_ctrl_q.memrd;
  assign ex_asrc      = ex_ctrl_q.asrc;
  assign ex_bsrc      = ex_ctrl_q.bsrc;
  assign ex_branch    = ex_ctrl_q.branch;
  assign ex_jump      = ex_ctrl_q.jump;
  assign ex_alusel    = ex_ctrl_q.alusel;
  assign ex_rd        = ex_rd_q;
  assign ex_rs1       = ex_rs1_q;
  assign ex_rs2       = ex_rs2_q;
  assign mem_valid    = mem_valid_q;
  assign mem_regwen   = mem_regwen_q;
  assign mem_memwen   = mem_memwen_q;
  assign mem_ddatasel = mem_ddatasel_q;
  assign mem_rd       = mem_rd_q;
  assign wb_valid     = wb_valid_q;
  assign wb_regwen    = wb_regwen_q;
  assign wb_ddatasel  = wb_ddatasel_q;
  assign wb_rd        = wb_rd_q;

endmodule
